// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared FSM type, Q-format constants and fixed-point helpers for poly_eval_engine
//
// Optional macro: POLY_SAT_EN
//   defined   : fx_mul_shift/fx_add clamp to [Q_MIN, Q_MAX] and report the clamp
//   undefined : results wrap two's-complement and the clamp flag is always 0
package poly_pkg;

    localparam int P_DATA_WIDTH = 32;
    localparam int P_FRAC_BITS  = 16;

    localparam logic signed [P_DATA_WIDTH-1:0] Q_MAX = {1'b0, {(P_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [P_DATA_WIDTH-1:0] Q_MIN = {1'b1, {(P_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_INIT,
        ST_ITER,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic [P_DATA_WIDTH-1:0] value;
        logic                    clamped;
    } fx_res_t;

    // Full-width signed product, arithmetic shift back to the Q format (truncates
    // toward minus infinity).
    function automatic fx_res_t fx_mul_shift(input logic signed [P_DATA_WIDTH-1:0] a,
                                             input logic signed [P_DATA_WIDTH-1:0] b);
        logic signed [2*P_DATA_WIDTH-1:0] prod;
        logic signed [2*P_DATA_WIDTH-1:0] shifted;
        fx_res_t r;
        prod      = (2*P_DATA_WIDTH)'(a) * (2*P_DATA_WIDTH)'(b);
        shifted   = prod >>> P_FRAC_BITS;
        r.value   = P_DATA_WIDTH'(shifted);
        r.clamped = 1'b0;
`ifdef POLY_SAT_EN
        // Fits only if everything above the kept word is a copy of its sign bit.
        if (shifted[2*P_DATA_WIDTH-1:P_DATA_WIDTH-1] != {(P_DATA_WIDTH+1){shifted[2*P_DATA_WIDTH-1]}}) begin
            r.value   = shifted[2*P_DATA_WIDTH-1] ? Q_MIN : Q_MAX;
            r.clamped = 1'b1;
        end
`endif
        return r;
    endfunction

    // One guard bit of headroom; overflow shows as guard bit != sign bit.
    function automatic fx_res_t fx_add(input logic signed [P_DATA_WIDTH-1:0] a,
                                       input logic signed [P_DATA_WIDTH-1:0] b);
        logic signed [P_DATA_WIDTH:0] sum;
        fx_res_t r;
        sum       = (P_DATA_WIDTH+1)'(a) + (P_DATA_WIDTH+1)'(b);
        r.value   = P_DATA_WIDTH'(sum);
        r.clamped = 1'b0;
`ifdef POLY_SAT_EN
        if (sum[P_DATA_WIDTH] != sum[P_DATA_WIDTH-1]) begin
            r.value   = sum[P_DATA_WIDTH] ? Q_MIN : Q_MAX;
            r.clamped = 1'b1;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/poly_eval_engine_if.sv
// rtl/poly_eval_engine_if.sv - sample/result streams, coefficient write port and status of poly_eval_engine
//
// master : the client (drives samples, coefficient writes, out_ready_i)
// slave  : the engine
interface poly_eval_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5,
    parameter int NUM_FUNCS  = 4
);
    localparam int FUNC_W = $clog2(NUM_FUNCS);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic [FUNC_W-1:0]     in_func_i;
    logic [ADDR_LINES-1:0] terms_i;
    logic                  coef_we_i;
    logic [FUNC_W-1:0]     coef_bank_i;
    logic [ADDR_LINES-1:0] coef_addr_i;
    logic [DATA_WIDTH-1:0] coef_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [FUNC_W-1:0]     out_func_o;
    logic                  idle_o;
    logic                  sat_o;

    modport master (
        output in_valid_i, in_data_i, in_func_i, terms_i,
               coef_we_i, coef_bank_i, coef_addr_i, coef_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_func_o, idle_o, sat_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_func_i, terms_i,
               coef_we_i, coef_bank_i, coef_addr_i, coef_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_func_o, idle_o, sat_o
    );

endinterface

// File: rtl/poly_in_fifo.sv
// rtl/poly_in_fifo.sv - synchronous sample FIFO with registered ready
//
// Ports: clk, rstn (async active-low); push/push_data write side;
// pop/head show-ahead read side; empty; ready = registered "not full".
module poly_in_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ready
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [PW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + (PW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            ready <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/poly_eval_engine.sv
// rtl/poly_eval_engine.sv - multi-bank fixed-point Horner polynomial evaluator
//
// Ports: clk_i, rstn_i (async active-low); bus (poly_eval_engine_if.slave):
//   in_valid_i/in_ready_o/in_data_i/in_func_i  sample stream into the FIFO
//   terms_i                                    degree N, captured at FIFO pop
//   coef_we_i/coef_bank_i/coef_addr_i/coef_data_i  coefficient write (only while idle)
//   out_valid_o/out_ready_i/out_data_o/out_func_o  result stream
//   idle_o, sat_o                              status
// Optional macro: POLY_SAT_EN (saturating arithmetic and sticky sat_o).
module poly_eval_engine
    import poly_pkg::*;
#(
    parameter int DATA_WIDTH = P_DATA_WIDTH,
    parameter int FRAC_BITS  = P_FRAC_BITS,
    parameter int ADDR_LINES = 5,
    parameter int NUM_FUNCS  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input logic               clk_i,
    input logic               rstn_i,
    poly_eval_engine_if.slave bus
);
    localparam int FUNC_W    = $clog2(NUM_FUNCS);
    localparam int RAM_AW    = FUNC_W + ADDR_LINES;
    localparam int RAM_WORDS = NUM_FUNCS * (2 ** ADDR_LINES);

    // The arithmetic helpers are built for the package word format.
    generate
        if (DATA_WIDTH != P_DATA_WIDTH || FRAC_BITS != P_FRAC_BITS) begin : g_fmt_check
            $error("poly_eval_engine: DATA_WIDTH/FRAC_BITS must match poly_pkg");
        end
    endgenerate

    state_t state_q;
    state_t state_d;
    logic   pop;

    logic [FUNC_W+DATA_WIDTH-1:0] head;
    logic                         fifo_empty;
    logic                         fifo_ready;

    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] coef_q;
    logic [FUNC_W-1:0]            func_q;
    logic [ADDR_LINES-1:0]        n_q;
    logic [ADDR_LINES-1:0]        k_q;
    logic [ADDR_LINES-1:0]        ptr_q;
    logic                         sat_q;
    logic                         idle;
    logic                         coef_wr;

    fx_res_t mul_r;
    fx_res_t add_r;

    logic [DATA_WIDTH-1:0] coef_ram [RAM_WORDS];

    poly_in_fifo #(
        .WIDTH (FUNC_W + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rstn      (rstn_i),
        .push      (bus.in_valid_i && fifo_ready),
        .push_data ({bus.in_func_i, bus.in_data_i}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .ready     (fifo_ready)
    );

    assign idle    = fifo_empty && (state_q == ST_IDLE);
    assign coef_wr = bus.coef_we_i && idle;

    // Coefficient RAM with a registered read address (ptr_q) and registered data
    // (coef_q). ptr_q is loaded with N at the pop and steps down every cycle, so
    // c[N] lands in INIT and c[k] lands in the ITER cycle that consumes it. Once
    // it runs past 0 it wraps and the reads are simply not used.
    always_ff @(posedge clk_i) begin
        if (coef_wr) coef_ram[RAM_AW'({bus.coef_bank_i, bus.coef_addr_i})] <= bus.coef_data_i;
        coef_q <= coef_ram[RAM_AW'({func_q, ptr_q})];
    end

    always_comb begin
        mul_r = fx_mul_shift(acc_q, x_q);
        add_r = fx_add(signed'(mul_r.value), coef_q);
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_INIT;
            ST_INIT:  state_d = (n_q == '0) ? ST_OUT : ST_ITER;
            ST_ITER:  if (k_q == '0) state_d = ST_OUT;
            ST_OUT:   if (bus.out_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            func_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            ptr_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        x_q    <= head[DATA_WIDTH-1:0];
                        func_q <= head[FUNC_W+DATA_WIDTH-1:DATA_WIDTH];
                        n_q    <= bus.terms_i;
                        ptr_q  <= bus.terms_i;
                    end
                end
                ST_FETCH: begin
                    ptr_q <= ptr_q - ADDR_LINES'(1);
                end
                ST_INIT: begin
                    acc_q <= coef_q;
                    k_q   <= n_q - ADDR_LINES'(1);
                    ptr_q <= ptr_q - ADDR_LINES'(1);
                end
                ST_ITER: begin
                    acc_q <= signed'(add_r.value);
                    k_q   <= k_q - ADDR_LINES'(1);
                    ptr_q <= ptr_q - ADDR_LINES'(1);
                    // Without POLY_SAT_EN the helpers never report a clamp, so this stays 0.
                    sat_q <= sat_q | mul_r.clamped | add_r.clamped;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = fifo_ready;
    assign bus.out_valid_o = (state_q == ST_OUT);
    assign bus.out_data_o  = acc_q;
    assign bus.out_func_o  = func_q;
    assign bus.idle_o      = idle;
`ifdef POLY_SAT_EN
    assign bus.sat_o       = sat_q;
`else
    assign bus.sat_o       = sat_q & 1'b0;
`endif

endmodule

// File: doc/poly_eval_engine.md
# poly_eval_engine

Multi-bank, fixed-point polynomial evaluator for the NLA hardware path. It is the next generation of the single-function Taylor MAC. Samples arrive on a valid/ready stream, each tagged with a function index. The block evaluates the selected polynomial by Horner's rule, one term per cycle, from a writable coefficient RAM, and returns results on a valid/ready output stream with back-pressure.

## Interface
- DATA_WIDTH, 32: signed sample/coefficient/result width.
- FRAC_BITS, 16: fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- ADDR_LINES, 5: coefficient address width per bank; maximum degree 2^ADDR_LINES-1.
- NUM_FUNCS, 4: number of coefficient banks (functions).
- FIFO_DEPTH, 16: input FIFO entries (power of two).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rstn_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  FIFO not full; a transfer occurs when in_valid_i && in_ready_o.
- in_data_i  in  DATA_WIDTH  sample x.
- in_func_i  in  $clog2(NUM_FUNCS)  bank select for this sample.
- terms_i  in  ADDR_LINES  polynomial degree N (N+1 coefficients); sampled at FIFO pop.
- coef_we_i  in  1  coefficient write strobe.
- coef_bank_i  in  $clog2(NUM_FUNCS)  write bank.
- coef_addr_i  in  ADDR_LINES  write address (power k of c[k]).
- coef_data_i  in  DATA_WIDTH  coefficient value.
- out_valid_o  out  1  result valid; held until accepted.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  DATA_WIDTH  result p(x).
- out_func_o  out  $clog2(NUM_FUNCS)  bank used for this result.
- idle_o  out  1  FIFO empty and FSM in IDLE.
- sat_o  out  1  sticky saturation flag.

## Operation
- Reset values: in_ready_o=1; out_valid_o=0; out_data_o=0; out_func_o=0; idle_o=1; sat_o=0. FIFO is emptied, FSM goes to IDLE, and the coefficient RAM contents are undefined.
- Coefficient writes take effect only when idle_o=1. They are silently dropped otherwise.
- FSM states: IDLE, FETCH, INIT, ITER, OUT.
  - IDLE: if the FIFO is not empty, pop it; capture x, func and N; issue a RAM read of c[N]; go to FETCH.
  - FETCH: one-cycle RAM read latency. Issue read of c[N-1] if N>0; go to INIT.
  - INIT: acc <= c[N]; k <= N-1. Go to OUT if N=0, else go to ITER.
  - ITER: acc <= sat(acc*x >>> FRAC_BITS) + c[k], with saturated add. Prefetch c[k-1]. Go to OUT when k=0.
  - OUT: out_valid_o=1 with out_data_o=acc. Go to IDLE on out_ready_i.
- Arithmetic:
  - Full 2*DATA_WIDTH signed product, arithmetic right shift by FRAC_BITS, truncation (no rounding).
  - Add is performed at DATA_WIDTH+1 bits, then clamped per Configuration.
- Simultaneous push and pop on a full FIFO: both succeed and occupancy is unchanged.
- Push when full: not accepted (in_ready_o=0).
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Pop to out_valid_o rising: N+3 cycles (pop in cycle 0, FETCH 1, INIT 2, ITER 3..N+2, OUT at N+3). For N=0 this is 3 cycles.
- Throughput: one result per N+4 cycles with out_ready_i held high. No overlap between samples.
- out_data_o and out_func_o are stable while out_valid_o && !out_ready_i.
- in_ready_o is registered and depends only on FIFO occupancy.
- Reset asserted mid-evaluation aborts it immediately. No result is emitted for the aborted sample.

## Configuration
- POLY_SAT_EN defined: multiply and add results are clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets sat_o, which clears only on reset.
- POLY_SAT_EN undefined: results wrap two's-complement and sat_o is tied 0.

## Structure
- Shared package poly_pkg holds:
  - the FSM state enum;
  - FRAC_BITS default and Q-format constants;
  - the saturating-add/shift function, guarded by POLY_SAT_EN.
- One sub-module, poly_in_fifo: synchronous FIFO storing {func, data}, with full/empty and registered ready.
- The coefficient RAM is inferred inline (NUM_FUNCS*2^ADDR_LINES words, one write port, one synchronous read port).

## Test plan
- Basic evaluation: bank 0 = {c0=c1=c2=0x0001_0000}, N=2, x=0x0002_0000 -> out_data_o=0x0007_0000, out_func_o=0, out_valid_o 5 cycles after the pop.
- Bank select: bank 1 = {c0=0, c1=0x0003_0000}, N=1, x=0xFFFF_0000 (-1.0) -> result 0xFFFD_0000. Bank 0 results are unaffected.
- Back-pressure: stream 20 samples with out_ready_i=0 -> in_ready_o deasserts after 17 accepted (1 in engine, 16 in FIFO). Release out_ready_i -> all 17 results emerge in order and out_data_o holds while stalled.
- Saturation with POLY_SAT_EN: c1=0x7FFF_0000, c0=0x0001_0000, N=1, x=0x0002_0000 -> out_data_o=0x7FFF_FFFF and sat_o=1. Without POLY_SAT_EN the result wraps and sat_o stays 0.
- Write gating: issue coef_we_i during an evaluation -> the RAM is unchanged and the next result uses the old coefficient.
- Reset mid-operation: assert rstn_i during ITER -> all outputs return to reset values, no out_valid_o appears afterwards, and idle_o=1.
